// File: rtl/gradient_kernel_engine.sv
// Prewitt-style gradient engine: KxK pixel window in, saturated Gx/Gy or |Gx|+|Gy| with edge flag out.
// Five-stage pipeline that advances only while downstream is ready; mode and threshold are latched per frame.
module gradient_kernel_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                                                    i_clk,
    input  logic                                                    i_aresetn,
    input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] i_window,
    input  logic                                                    i_data_valid,
    input  logic                                                    i_start_of_frame,
    input  logic                                                    i_mode,
    input  logic [OUT_WIDTH-1:0]                                    i_threshold,
    input  logic                                                    i_ready,
    output logic                                                    o_ready,
    output logic [2*OUT_WIDTH-1:0]                                  o_data,
    output logic                                                    o_data_valid,
    output logic                                                    o_start_of_frame
);
    localparam int K  = KERNEL_SIZE;
    localparam int H  = (K - 1) / 2;
    localparam int OW = OUT_WIDTH;
    localparam int GW = DATA_WIDTH + $clog2(K * K * H) + 2;
    // Extended width holds |Gx|+|Gy| and every clamp bound without wrapping.
    localparam int EW = ((GW > OW) ? GW : OW) + 2;

    typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0] window_t;
    typedef logic [GW-1:0]                       sum_t;
    typedef logic signed [GW-1:0]                grad_t;
    typedef logic signed [EW-1:0]                ext_t;

    localparam ext_t SMAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam ext_t SMIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam ext_t UMAX = {{(EW-OW){1'b0}}, {OW{1'b1}}};

    function automatic grad_t weighted(input int w, input sum_t s);
        grad_t w_g;
        w_g = grad_t'(w);
        return w_g * $signed(s);
    endfunction

    function automatic logic [OW-1:0] sat_s(input ext_t v);
        logic [OW-1:0] r;
        if (v > SMAX) begin
            r = SMAX[OW-1:0];
        end else if (v < SMIN) begin
            r = SMIN[OW-1:0];
        end else begin
            r = v[OW-1:0];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] sat_u(input ext_t v);
        logic [OW-1:0] r;
        if (v > UMAX) begin
            r = UMAX[OW-1:0];
        end else begin
            r = v[OW-1:0];
        end
        return r;
    endfunction

    function automatic ext_t abs_e(input ext_t v);
        return v[EW-1] ? -v : v;
    endfunction

    window_t                 win_q;
    logic [4:0]              vld_q;
    logic [4:0]              sof_q;
    logic                    frame_mode_q;
    logic [OW-1:0]           frame_thr_q;
    logic [2:0]              mode_q;
    logic [2:0][OW-1:0]      thr_q;
    logic [K-1:0][GW-1:0]    col_q;
    logic [K-1:0][GW-1:0]    row_q;
    grad_t                   gx_q;
    grad_t                   gy_q;
    logic [2*OW-1:0]         res_q;
    logic [2*OW-1:0]         data_q;

    logic                    sof_take_s;
    logic                    mode_src_s;
    logic [OW-1:0]           thr_src_s;
    logic [K-1:0][GW-1:0]    col_sum_s;
    logic [K-1:0][GW-1:0]    row_sum_s;
    grad_t                   gx_s;
    grad_t                   gy_s;
    ext_t                    gx_e_s;
    ext_t                    gy_e_s;
    ext_t                    mag_s;
    logic [OW-1:0]           mag_sat_s;
    logic                    flag_s;
    logic [2*OW-1:0]         res_s;

    assign sof_take_s       = i_data_valid & i_start_of_frame;
    assign o_ready          = i_ready;
    assign o_data           = data_q;
    assign o_data_valid     = vld_q[4];
    assign o_start_of_frame = sof_q[4];

    // Mode source for S1: a valid SOF window uses the live inputs, all others the frame registers.
    always_comb begin
        mode_src_s = frame_mode_q;
        thr_src_s  = frame_thr_q;
        if (sof_take_s) begin
            mode_src_s = i_mode;
            thr_src_s  = i_threshold;
        end else begin
            mode_src_s = frame_mode_q;
            thr_src_s  = frame_thr_q;
        end
    end

    // S2: per-column and per-row pixel sums of the registered window.
    always_comb begin
        col_sum_s = '0;
        row_sum_s = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                col_sum_s[c] = col_sum_s[c] + sum_t'(win_q[r][c]);
                row_sum_s[r] = row_sum_s[r] + sum_t'(win_q[r][c]);
            end
        end
    end

    // S3: weighted combine; the centre column and row carry zero weight and are skipped.
    always_comb begin
        gx_s = '0;
        gy_s = '0;
        for (int c = 0; c < H; c++) begin
            gx_s = gx_s + weighted(c - H, col_q[c]);
        end
        for (int c = H + 1; c < K; c++) begin
            gx_s = gx_s + weighted(c - H, col_q[c]);
        end
        for (int r = 0; r < H; r++) begin
            gy_s = gy_s + weighted(H - r, row_q[r]);
        end
        for (int r = H + 1; r < K; r++) begin
            gy_s = gy_s + weighted(H - r, row_q[r]);
        end
    end

    // S4: mode operation and saturation, using the mode that travelled with this window.
    always_comb begin
        gx_e_s    = ext_t'(gx_q);
        gy_e_s    = ext_t'(gy_q);
        mag_s     = abs_e(gx_e_s) + abs_e(gy_e_s);
        mag_sat_s = sat_u(mag_s);
        flag_s    = (mag_sat_s >= thr_q[2]);
        res_s     = '0;
        if (mode_q[2]) begin
            res_s = {{(OW-1){1'b0}}, flag_s, mag_sat_s};
        end else begin
            res_s = {sat_s(gy_e_s), sat_s(gx_e_s)};
        end
    end

    // Pipeline registers, frame latch and valid/SOF taps, all gated by downstream ready.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            win_q        <= '0;
            vld_q        <= '0;
            sof_q        <= '0;
            frame_mode_q <= 1'b0;
            frame_thr_q  <= '0;
            mode_q       <= '0;
            thr_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            res_q        <= '0;
            data_q       <= '0;
        end else if (i_ready) begin
            win_q  <= i_window;
            vld_q  <= {vld_q[3:0], i_data_valid};
            sof_q  <= {sof_q[3:0], sof_take_s};
            if (sof_take_s) begin
                frame_mode_q <= i_mode;
                frame_thr_q  <= i_threshold;
            end
            mode_q <= {mode_q[1:0], mode_src_s};
            thr_q  <= {thr_q[1:0], thr_src_s};
            col_q  <= col_sum_s;
            row_q  <= row_sum_s;
            gx_q   <= gx_s;
            gy_q   <= gy_s;
            res_q  <= res_s;
            data_q <= res_q;
        end
    end

endmodule

// File: tb/tb_gradient_kernel_engine.sv
// Self-checking bench for gradient_kernel_engine: directed spec vectors plus randomized streams
// scored against a plain-arithmetic gradient model with per-frame mode latching.
module tb_gradient_kernel_engine;
    localparam int DW = 8;
    localparam int K5 = 5;
    localparam int K3 = 3;
    typedef logic [K5-1:0][K5-1:0][DW-1:0] win5_t;
    typedef logic [K3-1:0][K3-1:0][DW-1:0] win3_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    win5_t       win5;
    win3_t       win3;
    logic        dv, sof, mode, rdy;
    logic [15:0] thr;
    logic        rdy_a, rdy_b, rdy_c;
    logic [31:0] data_a, data_c;
    logic [15:0] data_b;
    logic        ov_a, ov_b, ov_c, os_a, os_b, os_c;

    int n_tests = 0;
    int n_fail  = 0;

    gradient_kernel_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(K5), .OUT_WIDTH(16)) dut_a (
        .i_clk(clk), .i_aresetn(rstn), .i_window(win5), .i_data_valid(dv),
        .i_start_of_frame(sof), .i_mode(mode), .i_threshold(thr), .i_ready(rdy),
        .o_ready(rdy_a), .o_data(data_a), .o_data_valid(ov_a), .o_start_of_frame(os_a));

    gradient_kernel_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(K5), .OUT_WIDTH(8)) dut_b (
        .i_clk(clk), .i_aresetn(rstn), .i_window(win5), .i_data_valid(dv),
        .i_start_of_frame(sof), .i_mode(mode), .i_threshold(thr[7:0]), .i_ready(rdy),
        .o_ready(rdy_b), .o_data(data_b), .o_data_valid(ov_b), .o_start_of_frame(os_b));

    gradient_kernel_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(K3), .OUT_WIDTH(16)) dut_c (
        .i_clk(clk), .i_aresetn(rstn), .i_window(win3), .i_data_valid(dv),
        .i_start_of_frame(sof), .i_mode(mode), .i_threshold(thr), .i_ready(rdy),
        .o_ready(rdy_c), .o_data(data_c), .o_data_valid(ov_c), .o_start_of_frame(os_c));

    // Reference: Gx = sum (c-2)*p, Gy = sum (2-r)*p over the 5x5 window.
    function automatic int gx5(input win5_t w);
        int s = 0;
        for (int r = 0; r < K5; r++)
            for (int c = 0; c < K5; c++)
                s += (c - 2) * int'(w[r][c]);
        return s;
    endfunction

    function automatic int gy5(input win5_t w);
        int s = 0;
        for (int r = 0; r < K5; r++)
            for (int c = 0; c < K5; c++)
                s += (2 - r) * int'(w[r][c]);
        return s;
    endfunction

    function automatic logic [31:0] pack(input int gx, input int gy, input logic m,
                                         input int t, input int ow);
        int mx, mn, mask, lo, hi, mag;
        mx   = (1 << (ow - 1)) - 1;
        mn   = -(1 << (ow - 1));
        mask = (1 << ow) - 1;
        if (!m) begin
            lo = (gx > mx) ? mx : ((gx < mn) ? mn : gx);
            hi = (gy > mx) ? mx : ((gy < mn) ? mn : gy);
            lo = lo & mask;
            hi = hi & mask;
        end else begin
            mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
            if (mag > mask) mag = mask;
            lo = mag;
            hi = (mag >= t) ? 1 : 0;
        end
        return (32'(hi) << ow) | 32'(lo);
    endfunction

    function automatic logic [31:0] m5(input win5_t w, input logic m, input int t, input int ow);
        return pack(gx5(w), gy5(w), m, t, ow);
    endfunction

    function automatic win5_t rand5();
        win5_t w;
        for (int r = 0; r < K5; r++)
            for (int c = 0; c < K5; c++)
                w[r][c] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        dv  = 1'b0;
        sof = 1'b0;
        rdy = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b1; dv = 1'b0; sof = 1'b0; mode = 1'b0; thr = 16'd0; rdy = 1'b1;
        win5 = '0; win3 = '0;
        #2 rstn = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (data_a !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_a); end
        n_tests++;
        if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ov_a); end
        n_tests++;
        if (os_a !== 1'b0) begin n_fail++; $display("FAIL reset_sof got %b want 0", os_a); end
        rstn = 1'b1;
        rdy = 1'b0;
        #1;
        n_tests++;
        if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL o_ready_low got %b want 0", rdy_a); end
        rdy = 1'b1;
        #1;
        n_tests++;
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL o_ready_high got %b want 1", rdy_a); end
        tick();
    endtask

    task automatic test_latency();
        for (int r = 0; r < K5; r++)
            for (int c = 0; c < K5; c++)
                win5[r][c] = 8'd200;
        dv = 1'b1; sof = 1'b1; mode = 1'b0; thr = 16'd0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin dv = 1'b0; sof = 1'b0; end
            n_tests++;
            if (k < 5) begin
                if (ov_a !== 1'b0) begin n_fail++; $display("FAIL latency_early k=%0d got %b want 0", k, ov_a); end
            end else begin
                if ({ov_a, os_a, data_a} !== {1'b1, 1'b1, 32'h0}) begin
                    n_fail++;
                    $display("FAIL uniform_out got v=%b s=%b d=%h want v=1 s=1 d=0", ov_a, os_a, data_a);
                end
            end
        end
        flush();
    endtask

    task automatic test_ramp_sat();
        win5_t       ws [4];
        logic [32:0] exp_a [4];
        logic [15:0] exp_b [4];
        int j;
        for (int r = 0; r < K5; r++)
            for (int c = 0; c < K5; c++) begin
                ws[0][r][c] = 8'(10 * c);
                ws[1][r][c] = 8'(10 * r);
                ws[2][r][c] = (c >= 3) ? 8'd255 : 8'd0;
                ws[3][r][c] = (c <= 1) ? 8'd255 : 8'd0;
            end
        exp_a = '{{1'b1, 32'h000001F4}, {1'b0, 32'hFE0C0000}, {1'b0, 32'h00000EF1}, {1'b0, 32'h0000F10F}};
        exp_b = '{16'h007F, 16'h8000, 16'h007F, 16'h0080};
        mode = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            if (t <= 4) begin
                win5 = ws[t-1]; dv = 1'b1; sof = (t == 1);
            end else begin
                dv = 1'b0; sof = 1'b0;
            end
            tick();
            j = t - 5;
            if (j >= 0) begin
                n_tests++;
                if ({ov_a, os_a, data_a} !== {1'b1, exp_a[j]}) begin
                    n_fail++;
                    $display("FAIL ramp_a[%0d] got v=%b s=%b d=%h want s/d=%h", j, ov_a, os_a, data_a, exp_a[j]);
                end
                n_tests++;
                if ({ov_b, data_b} !== {1'b1, exp_b[j]}) begin
                    n_fail++;
                    $display("FAIL sat8_b[%0d] got v=%b d=%h want %h", j, ov_b, data_b, exp_b[j]);
                end
            end
        end
        flush();
    endtask

    task automatic test_magnitude();
        logic [31:0] exp_c [2];
        exp_c = '{32'h0000003C, 32'h000100B4};
        mode = 1'b1; thr = 16'd100;
        for (int t = 1; t <= 6; t++) begin
            if (t <= 2) begin
                for (int r = 0; r < K3; r++)
                    for (int c = 0; c < K3; c++)
                        win3[r][c] = 8'(((t == 1) ? 10 : 30) * c);
                dv = 1'b1; sof = (t == 1);
            end else begin
                dv = 1'b0; sof = 1'b0;
            end
            tick();
            if (t >= 5) begin
                n_tests++;
                if ({ov_c, data_c} !== {1'b1, exp_c[t-5]}) begin
                    n_fail++;
                    $display("FAIL mag_c[%0d] got v=%b d=%h want %h", t - 5, ov_c, data_c, exp_c[t-5]);
                end
            end
        end
        flush();
    endtask

    task automatic test_stream();
        logic [32:0] q [$];
        logic [32:0] exp;
        logic [33:0] snap;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic fm = 1'b0;
        int ft = 0;
        win5_t w;
        mode = 1'b0;
        thr = 16'($urandom_range(0, 65535));
        while ((sent < 20 || q.size() != 0) && cyc < 200) begin
            rdy = !(cyc >= 8 && cyc < 11);
            if (ov_a && rdy) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra got %h want no output", data_a);
                end else begin
                    exp = q.pop_front();
                    got++;
                    if ({os_a, data_a} !== exp) begin
                        n_fail++;
                        $display("FAIL stream[%0d] got s=%b d=%h want %h", got - 1, os_a, data_a, exp);
                    end
                end
            end
            if (rdy) begin
                if (sent < 20 && cyc != 4) begin
                    w = rand5(); win5 = w; dv = 1'b1; sof = (sent == 0);
                    if (sof) begin fm = mode; ft = int'(thr); end
                    q.push_back({sof, m5(w, fm, ft, 16)});
                    sent++;
                end else begin
                    dv = 1'b0; sof = 1'b0;
                end
            end
            if (cyc == 8) snap = {ov_a, os_a, data_a};
            tick();
            if (cyc >= 8 && cyc < 11) begin
                n_tests++;
                if ({ov_a, os_a, data_a} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got %h want %h", cyc, {ov_a, os_a, data_a}, snap);
                end
            end
            cyc++;
        end
        n_tests++;
        if (got != 20 || cyc >= 200) begin
            n_fail++;
            $display("FAIL stream_count got %0d want 20 (cycles %0d)", got, cyc);
        end
        flush();
    endtask

    task automatic test_mode_latch();
        logic [11:0] dv_v   = 12'b1111_1110_1111;
        logic [11:0] sof_v  = 12'b1000_1001_0001;
        logic [11:0] mode_v = 12'b0000_1111_0000;
        logic [32:0] q [$];
        logic [32:0] exp;
        logic fm = 1'b0;
        int ft = 0;
        int idx = 0;
        win5_t w;
        rdy = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            if (ov_a) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL latch_extra got %h want no output", data_a);
                end else begin
                    exp = q.pop_front();
                    if ({os_a, data_a} !== exp) begin
                        n_fail++;
                        $display("FAIL latch[%0d] got s=%b d=%h want %h", idx, os_a, data_a, exp);
                    end
                    idx++;
                end
            end
            if (cyc < 12) begin
                w = rand5(); win5 = w;
                dv = dv_v[cyc]; sof = sof_v[cyc]; mode = mode_v[cyc];
                thr = 16'($urandom_range(0, 4000));
                if (dv && sof) begin fm = mode; ft = int'(thr); end
                if (dv) q.push_back({sof, m5(w, fm, ft, 16)});
            end else begin
                dv = 1'b0; sof = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (q.size() != 0 || idx != 11) begin
            n_fail++;
            $display("FAIL latch_count got %0d want 11", idx);
        end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        mode = 1'b1; thr = 16'd500; rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            win5 = rand5(); dv = 1'b1; sof = (i == 0);
            tick();
        end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if ({ov_a, os_a, data_a} !== 34'h0) begin
            n_fail++;
            $display("FAIL midreset_clear got v=%b s=%b d=%h want 0", ov_a, os_a, data_a);
        end
        dv = 1'b0; sof = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) begin
            tick();
            if (ov_a) stale++;
        end
        n_tests++;
        if (stale != 0) begin n_fail++; $display("FAIL stale_valid got %0d want 0", stale); end
        for (int r = 0; r < K5; r++)
            for (int c = 0; c < K5; c++)
                win5[r][c] = 8'(10 * c);
        dv = 1'b1; sof = 1'b0; mode = 1'b1; thr = 16'd0;
        tick();
        dv = 1'b0;
        repeat (4) tick();
        n_tests++;
        if ({ov_a, os_a, data_a} !== {1'b1, 1'b0, 32'h000001F4}) begin
            n_fail++;
            $display("FAIL mode_after_reset got v=%b s=%b d=%h want v=1 s=0 d=000001f4", ov_a, os_a, data_a);
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ramp_sat();
        test_magnitude();
        test_stream();
        test_mode_latch();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
